axis_rr_arbiter: RTL and testbench



---
 rtl/params_pkg.sv | 26 ++
 rtl/axis_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/axis_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared parameters and types for the stream arbitration path.
package params_pkg;

  // Default stream data width seen by the DMA S2MM port.
  localparam int DATA_WIDTH = 32;

  // Default number of stream producers sharing the S2MM port.
  localparam int NUM_SRC_DEFAULT = 4;

  // Default beat count at which a packet without tlast is flagged.
  localparam int MAX_PKT_BEATS_DEFAULT = 256;

  // The per-packet beat counter width and its saturation value.
  localparam int BEAT_CNT_WIDTH = 16;
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_CNT_MAX = '1;

  // Width of the packet counter exposed to the register path.
  localparam int PKT_CNT_WIDTH = 32;

  // Arbiter FSM: waiting for a request, or holding a grant for one packet.
  typedef enum logic {
    IDLE,
    XFER
  } arb_state_e;

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder. The search starts at the
// source just after last_grant and wraps modulo NUM_SRC, so the source
// that was served most recently has the lowest priority.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               any_req
);

  // Candidate index and request for each search position; position 0 is
  // the highest priority (last_grant + 1), position NUM_SRC-1 the lowest.
  logic [IW-1:0]      cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_req;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      // One extra bit so last_grant + offset never overflows before the wrap.
      logic [IW:0] sum;
      assign sum = {1'b0, last_grant} + (IW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IW+1)'(NUM_SRC))
                          ? IW'(sum - (IW+1)'(NUM_SRC))
                          : sum[IW-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  assign any_req = |req;

  // Walk from lowest to highest priority so the nearest requester wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter in front of the DMA S2MM stream port.
// A grant is taken in IDLE and held until the beat carrying tlast, so
// packets from different producers never interleave. The granted source
// is forwarded combinationally; the arbiter adds no buffering.
module axis_rr_arbiter #(
  parameter int NUM_SRC       = params_pkg::NUM_SRC_DEFAULT,
  parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_PKT_BEATS = params_pkg::MAX_PKT_BEATS_DEFAULT
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0]  src_tkeep,
  input  logic [NUM_SRC-1:0]             src_tvalid,
  input  logic [NUM_SRC-1:0]             src_tlast,
  output logic [NUM_SRC-1:0]             src_tready,
  output logic [DATA_WIDTH-1:0]          s_axis_s2mm_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_s2mm_tkeep,
  output logic                           s_axis_s2mm_tvalid,
  output logic                           s_axis_s2mm_tlast,
  input  logic                           s_axis_s2mm_tready,
  output logic [$clog2(NUM_SRC)-1:0]     s_axis_s2mm_tid,
  output logic                           busy,
  output logic                           pkt_done,
  output logic [31:0]                    pkt_count,
  output logic                           overlong_err,
  input  logic                           err_clr
);

  import params_pkg::*;

  localparam int IW = $clog2(NUM_SRC);
  // beat_cnt value on the handshake that completes MAX_PKT_BEATS beats.
  localparam logic [BEAT_CNT_WIDTH-1:0] OVERLONG_AT =
    BEAT_CNT_WIDTH'(MAX_PKT_BEATS - 1);

  // Per-source views of the packed input buses.
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [KEEP_WIDTH-1:0] src_keep [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = src_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_keep[gi] = src_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
    end
  endgenerate

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             grant_q, grant_d;
  logic [IW-1:0]             last_grant_q, last_grant_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic                      pkt_done_q, pkt_done_d;
  logic                      overlong_q, overlong_d;

  logic [IW-1:0] pick_grant;
  logic          pick_any;
  logic          in_xfer;
  logic          handshake;
  logic          overlong_set;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_rr_pick (
    .req        (src_tvalid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any_req    (pick_any)
  );

  assign in_xfer = (state_q == XFER);

  // Forward the granted source while a packet is open; everything is zero in IDLE.
  always_comb begin
    s_axis_s2mm_tdata  = '0;
    s_axis_s2mm_tkeep  = '0;
    s_axis_s2mm_tvalid = 1'b0;
    s_axis_s2mm_tlast  = 1'b0;
    s_axis_s2mm_tid    = '0;
    src_tready         = '0;
    if (in_xfer) begin
      s_axis_s2mm_tdata   = src_data[grant_q];
      s_axis_s2mm_tkeep   = src_keep[grant_q];
      s_axis_s2mm_tvalid  = src_tvalid[grant_q];
      s_axis_s2mm_tlast   = src_tlast[grant_q];
      s_axis_s2mm_tid     = grant_q;
      src_tready[grant_q] = s_axis_s2mm_tready;
    end
  end

  // Output tvalid is already forced low outside XFER, so this is a real beat.
  assign handshake    = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
  assign overlong_set = handshake & ~s_axis_s2mm_tlast &
                        (beat_cnt_q == OVERLONG_AT);

  // Next-state logic: grant selection, beat/packet counting and error flag.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_count_d  = pkt_count_q;
    pkt_done_d   = 1'b0;
    overlong_d   = overlong_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_grant;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (handshake) begin
          if (beat_cnt_q != BEAT_CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (s_axis_s2mm_tlast) begin
            last_grant_d = grant_q;
            pkt_count_d  = pkt_count_q + 1'b1;
            pkt_done_d   = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new overlong event takes priority over a simultaneous clear.
    if (err_clr) begin
      overlong_d = 1'b0;
    end
    if (overlong_set) begin
      overlong_d = 1'b1;
    end
  end

  // State registers; reset abandons any open packet without a closing beat.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      pkt_count_q  <= '0;
      pkt_done_q   <= 1'b0;
      overlong_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_count_q  <= pkt_count_d;
      pkt_done_q   <= pkt_done_d;
      overlong_q   <= overlong_d;
    end
  end

  assign busy         = in_xfer;
  assign pkt_done     = pkt_done_q;
  assign pkt_count    = pkt_count_q;
  assign overlong_err = overlong_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed testbench for axis_rr_arbiter: single packet, round-robin
// rotation, back-pressure, mid-packet gap, overlong flag and mid-packet reset.
module tb_axis_rr_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 32;
  localparam int KW   = 4;
  localparam int MAXB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  src_tdata;
  logic [NS*KW-1:0]  src_tkeep;
  logic [NS-1:0]     src_tvalid;
  logic [NS-1:0]     src_tlast;
  logic [NS-1:0]     src_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        m_tid;
  logic              busy;
  logic              pkt_done;
  logic [31:0]       pkt_count;
  logic              overlong_err;
  logic              err_clr;

  int checks = 0;
  int errors = 0;

  // Observed control bundle: {tvalid, tlast, tid, busy, pkt_done, src_tready}
  logic [9:0] ctl;
  assign ctl = {m_tvalid, m_tlast, m_tid, busy, pkt_done, src_tready};

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .NUM_SRC       (NS),
    .DATA_WIDTH    (DW),
    .KEEP_WIDTH    (KW),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .axi_aclk           (clk),
    .axi_reset          (rst),
    .src_tdata          (src_tdata),
    .src_tkeep          (src_tkeep),
    .src_tvalid         (src_tvalid),
    .src_tlast          (src_tlast),
    .src_tready         (src_tready),
    .s_axis_s2mm_tdata  (m_tdata),
    .s_axis_s2mm_tkeep  (m_tkeep),
    .s_axis_s2mm_tvalid (m_tvalid),
    .s_axis_s2mm_tlast  (m_tlast),
    .s_axis_s2mm_tready (m_tready),
    .s_axis_s2mm_tid    (m_tid),
    .busy               (busy),
    .pkt_done           (pkt_done),
    .pkt_count          (pkt_count),
    .overlong_err       (overlong_err),
    .err_clr            (err_clr)
  );

  function automatic logic [9:0] exp_ctl(logic v, logic l, logic [1:0] t,
                                         logic b, logic d, logic [3:0] r);
    return {v, l, t, b, d, r};
  endfunction

  task automatic set_src(input int i, input logic v, input logic [31:0] d,
                         input logic l);
    src_tvalid[i]        = v;
    src_tdata[i*DW +: DW] = d;
    src_tkeep[i*KW +: KW] = 4'(i + 1);
    src_tlast[i]         = l;
  endtask

  task automatic idle_all();
    src_tvalid = '0;
    src_tlast  = '0;
    src_tdata  = '0;
    src_tkeep  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    err_clr = 1'b0;
    m_tready = 1'b1;
    idle_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", ctl, 10'd0);
    end
    checks++;
    if ({m_tdata, m_tkeep} !== 36'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", m_tdata, m_tkeep);
    end
    checks++;
    if ({pkt_count, overlong_err} !== 33'd0) begin
      errors++;
      $display("FAIL reset_status got cnt=%0d err=%b exp 0/0", pkt_count, overlong_err);
    end
    $display("test_reset done");
    next_cycle();
  endtask

  task automatic test_single_packet();
    logic [9:0] e;
    set_src(0, 1'b1, 32'hA0, 1'b0);
    @(negedge clk);
    checks++;
    e = exp_ctl(0, 0, 2'd0, 0, 0, 4'b0000);
    if (ctl !== e) begin
      errors++;
      $display("FAIL t1_idle ctl got %b exp %b", ctl, e);
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      set_src(0, 1'b1, 32'hA0 + k, k == 3);
      @(negedge clk);
      e = exp_ctl(1, k == 3, 2'd0, 1, 0, 4'b0001);
      checks++;
      if (ctl !== e) begin
        errors++;
        $display("FAIL t1_beat%0d ctl got %b exp %b", k, ctl, e);
      end
      checks++;
      if (m_tdata !== 32'hA0 + k || m_tkeep !== 4'h1) begin
        errors++;
        $display("FAIL t1_data%0d got %h/%h exp %h/1", k, m_tdata, m_tkeep, 32'hA0 + k);
      end
      $display("t1 beat %0d tdata=%h tid=%0d", k, m_tdata, m_tid);
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    e = exp_ctl(0, 0, 2'd0, 0, 1, 4'b0000);
    checks++;
    if (ctl !== e || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL t1_done ctl got %b cnt %0d exp %b cnt 1", ctl, pkt_count, e);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL t1_done_clear ctl got %b exp %b", ctl, 10'd0);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int sp[NS];
    int sb[NS];
    logic [NS-1:0] fire;
    logic [9:0] e;
    logic [31:0] ed;
    int ph;
    int p;
    rst = 1'b1;
    idle_all();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sp[i] = 0;
      sb[i] = 0;
    end
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (sp[i] < 2)
          set_src(i, 1'b1, {16'h0, 8'(i), 4'(sp[i]), 4'(sb[i])}, sb[i] == 1);
        else
          set_src(i, 1'b0, 32'h0, 1'b0);
      end
      @(negedge clk);
      ph = c % 3;
      p  = c / 3;
      if (ph == 0)
        e = exp_ctl(0, 0, 2'd0, 0, c > 0, 4'b0000);
      else
        e = exp_ctl(1, ph == 2, 2'(p % 4), 1, 0, 4'(1 << (p % 4)));
      checks++;
      if (ctl !== e) begin
        errors++;
        $display("FAIL rr_c%0d ctl got %b exp %b", c, ctl, e);
      end
      if (ph != 0) begin
        ed = {16'h0, 8'(p % 4), 4'(p / 4), 4'(ph - 1)};
        checks++;
        if (m_tdata !== ed) begin
          errors++;
          $display("FAIL rr_data_c%0d got %h exp %h", c, m_tdata, ed);
        end
        $display("rr cycle %0d tid=%0d tdata=%h", c, m_tid, m_tdata);
      end
      fire = src_tvalid & src_tready;
      next_cycle();
      for (int i = 0; i < NS; i++) begin
        if (fire[i]) begin
          if (sb[i] == 1) begin
            sb[i] = 0;
            sp[i]++;
          end else begin
            sb[i]++;
          end
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd8) begin
      errors++;
      $display("FAIL rr_count got %0d exp 8", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    logic [0:5] pat;
    int bexp[6];
    int b;
    logic f;
    logic [9:0] e;
    pat  = 6'b100101;
    bexp = '{0, 1, 1, 1, 2, 2};
    idle_all();
    m_tready = 1'b1;
    set_src(1, 1'b1, 32'hB0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL bp_idle ctl got %b exp %b", ctl, 10'd0);
    end
    next_cycle();
    b = 0;
    for (int j = 0; j < 6; j++) begin
      m_tready = pat[j];
      set_src(1, 1'b1, 32'hB0 + b, b == 2);
      @(negedge clk);
      e = exp_ctl(1, bexp[j] == 2, 2'd1, 1, 0, pat[j] ? 4'b0010 : 4'b0000);
      checks++;
      if (ctl !== e) begin
        errors++;
        $display("FAIL bp_ctl%0d got %b exp %b", j, ctl, e);
      end
      checks++;
      if (m_tdata !== 32'hB0 + bexp[j]) begin
        errors++;
        $display("FAIL bp_data%0d got %h exp %h", j, m_tdata, 32'hB0 + bexp[j]);
      end
      $display("bp cycle %0d tready=%b tdata=%h", j, m_tready, m_tdata);
      f = src_tready[1];
      next_cycle();
      if (f) b++;
    end
    m_tready = 1'b1;
    idle_all();
    @(negedge clk);
    e = exp_ctl(0, 0, 2'd0, 0, 1, 4'b0000);
    checks++;
    if (ctl !== e || pkt_count !== 32'd9 || b !== 3) begin
      errors++;
      $display("FAIL bp_done ctl %b cnt %0d beats %0d exp %b cnt 9 beats 3", ctl, pkt_count, b, e);
    end
    next_cycle();
  endtask

  task automatic test_gap();
    logic [9:0] e;
    idle_all();
    set_src(2, 1'b1, 32'hC0, 1'b0);
    set_src(3, 1'b1, 32'hD0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== 10'd0) begin
      errors++;
      $display("FAIL gap_idle ctl got %b exp %b", ctl, 10'd0);
    end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      set_src(2, 1'b1, 32'hC0 + k, 1'b0);
      @(negedge clk);
      e = exp_ctl(1, 0, 2'd2, 1, 0, 4'b0100);
      checks++;
      if (ctl !== e || m_tdata !== 32'hC0 + k) begin
        errors++;
        $display("FAIL gap_beat%0d ctl %b data %h exp %b %h", k, ctl, m_tdata, e, 32'hC0 + k);
      end
      next_cycle();
    end
    for (int g = 0; g < 5; g++) begin
      set_src(2, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      e = exp_ctl(0, 0, 2'd2, 1, 0, 4'b0100);
      checks++;
      if (ctl !== e) begin
        errors++;
        $display("FAIL gap_hold%0d ctl got %b exp %b", g, ctl, e);
      end
      $display("gap cycle %0d tid=%0d src_tready=%b", g, m_tid, src_tready);
      next_cycle();
    end
    set_src(2, 1'b1, 32'hC2, 1'b1);
    @(negedge clk);
    e = exp_ctl(1, 1, 2'd2, 1, 0, 4'b0100);
    checks++;
    if (ctl !== e || m_tdata !== 32'hC2) begin
      errors++;
      $display("FAIL gap_last ctl %b data %h exp %b c2", ctl, m_tdata, e);
    end
    next_cycle();
    set_src(2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    e = exp_ctl(0, 0, 2'd0, 0, 1, 4'b0000);
    checks++;
    if (ctl !== e) begin
      errors++;
      $display("FAIL gap_bubble ctl got %b exp %b", ctl, e);
    end
    next_cycle();
    @(negedge clk);
    e = exp_ctl(1, 1, 2'd3, 1, 0, 4'b1000);
    checks++;
    if (ctl !== e || m_tdata !== 32'hD0) begin
      errors++;
      $display("FAIL gap_src3 ctl %b data %h exp %b d0", ctl, m_tdata, e);
    end
    next_cycle();
    set_src(3, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (pkt_done !== 1'b1 || pkt_count !== 32'd11) begin
      errors++;
      $display("FAIL gap_count done %b cnt %0d exp 1 cnt 11", pkt_done, pkt_count);
    end
    next_cycle();
  endtask

  task automatic test_overlong();
    logic [9:0] e;
    idle_all();
    set_src(0, 1'b1, 32'hE0, 1'b0);
    @(negedge clk);
    checks++;
    if (overlong_err !== 1'b0 || ctl !== 10'd0) begin
      errors++;
      $display("FAIL ol_idle err %b ctl %b exp 0 0", overlong_err, ctl);
    end
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      set_src(0, 1'b1, 32'hE0 + k, k == 9);
      err_clr = (k == 7);
      @(negedge clk);
      e = exp_ctl(1, k == 9, 2'd0, 1, 0, 4'b0001);
      checks++;
      if (ctl !== e || m_tdata !== 32'hE0 + k) begin
        errors++;
        $display("FAIL ol_beat%0d ctl %b data %h exp %b %h", k, ctl, m_tdata, e, 32'hE0 + k);
      end
      checks++;
      if (overlong_err !== (k >= 8)) begin
        errors++;
        $display("FAIL ol_flag%0d got %b exp %b", k, overlong_err, k >= 8);
      end
      $display("ol beat %0d tdata=%h overlong=%b", k, m_tdata, overlong_err);
      next_cycle();
    end
    err_clr = 1'b0;
    idle_all();
    @(negedge clk);
    e = exp_ctl(0, 0, 2'd0, 0, 1, 4'b0000);
    checks++;
    if (ctl !== e || pkt_count !== 32'd12 || overlong_err !== 1'b1) begin
      errors++;
      $display("FAIL ol_done ctl %b cnt %0d err %b exp %b 12 1", ctl, pkt_count, overlong_err, e);
    end
    next_cycle();
    err_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (overlong_err !== 1'b1) begin
      errors++;
      $display("FAIL ol_pre_clr got %b exp 1", overlong_err);
    end
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overlong_err !== 1'b0) begin
      errors++;
      $display("FAIL ol_clr got %b exp 0", overlong_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_packet();
    logic [9:0] e;
    idle_all();
    set_src(1, 1'b1, 32'hF0, 1'b0);
    @(negedge clk);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      set_src(1, 1'b1, 32'hF0 + k, 1'b0);
      @(negedge clk);
      e = exp_ctl(1, 0, 2'd1, 1, 0, 4'b0010);
      checks++;
      if (ctl !== e || m_tdata !== 32'hF0 + k) begin
        errors++;
        $display("FAIL rm_beat%0d ctl %b data %h exp %b %h", k, ctl, m_tdata, e, 32'hF0 + k);
      end
      next_cycle();
    end
    set_src(1, 1'b1, 32'hF2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    e = exp_ctl(1, 0, 2'd1, 1, 0, 4'b0010);
    checks++;
    if (ctl !== e || m_tdata !== 32'hF2) begin
      errors++;
      $display("FAIL rm_pre ctl %b data %h exp %b f2", ctl, m_tdata, e);
    end
    next_cycle();
    rst = 1'b0;
    set_src(0, 1'b1, 32'h10, 1'b1);
    set_src(1, 1'b1, 32'hF0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== 10'd0 || m_tdata !== 32'd0 || m_tkeep !== 4'd0 ||
        pkt_count !== 32'd0 || overlong_err !== 1'b0) begin
      errors++;
      $display("FAIL rm_post ctl %b data %h keep %h cnt %0d exp all 0",
               ctl, m_tdata, m_tkeep, pkt_count);
    end
    next_cycle();
    @(negedge clk);
    e = exp_ctl(1, 1, 2'd0, 1, 0, 4'b0001);
    checks++;
    if (ctl !== e || m_tdata !== 32'h10) begin
      errors++;
      $display("FAIL rm_regrant ctl %b data %h exp %b 10", ctl, m_tdata, e);
    end
    $display("rm regrant tid=%0d tdata=%h", m_tid, m_tdata);
    next_cycle();
    idle_all();
    @(negedge clk);
    e = exp_ctl(0, 0, 2'd0, 0, 1, 4'b0000);
    checks++;
    if (ctl !== e || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL rm_count ctl %b cnt %0d exp %b 1", ctl, pkt_count, e);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_gap();
    test_overlong();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
